// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator car controller:
// the controller state encoding and the active-high {a..g} seven-segment
// patterns for the digits 0..9.
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVING,
    DOOR_OPEN,
    FIRE_RECALL,
    FIRE_PARKED
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

endpackage

// File: rtl/elevator_seg_dec.sv
// Combinational BCD to seven-segment decoder, segments {a..g}, active high.
// Codes above 9 blank the display.
module elevator_seg_dec
  import elevator_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    seg = 7'b0000000;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN (collective) elevator car controller: latches landing calls, serves
// them in sweep order, sequences the door with a timer, holds the door on
// overload / obstruction and performs fire-alarm recall to FIRE_FLOOR.
// Optional feature macro ELEV_SEG_EN: when defined, seg carries a registered
// seven-segment image of the floor; otherwise seg is tied low.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6,
  parameter int FIRE_FLOOR    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  overload,
  input  logic                  firealarm,
  input  logic                  person_detected,
  output logic                  door_open,
  output logic                  door_closed,
  output logic [FLOOR_W-1:0]    floor,
  output logic [3:0]            bcd_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  fire_mode,
  output logic [6:0]            seg
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FIRE_F      = FLOOR_W'(FIRE_FLOOR);

  state_t                  state;
  logic [TW-1:0]           travel_cnt;
  logic [DW-1:0]           door_cnt;
  logic [FLOOR_W-1:0]      arrive_floor;
  logic [NUM_FLOORS-1:0]   pending_merge;
  logic                    any_above, any_below, arr_above, arr_below;

  // One-hot mask of a landing, used to clear its call when its door opens
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit = NUM_FLOORS'(1) << f;
  endfunction

  // Floor the car reaches at the end of the current hop, clamped to the shaft
  always_comb begin
    arrive_floor = floor;
    if (dir_up && floor != TOP_FLOOR)
      arrive_floor = floor + FLOOR_W'(1);
    else if (!dir_up && floor != '0)
      arrive_floor = floor - FLOOR_W'(1);
  end

  // Calls above/below the current floor and the floor being arrived at
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    arr_above = 1'b0;
    arr_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (i > int'(floor))        any_above = 1'b1;
        if (i < int'(floor))        any_below = 1'b1;
        if (i > int'(arrive_floor)) arr_above = 1'b1;
        if (i < int'(arrive_floor)) arr_below = 1'b1;
      end
    end
  end

  // New calls merge into the latch; fire service discards all calls
  always_comb begin
    pending_merge = pending | req;
    if (firealarm || fire_mode)
      pending_merge = '0;
  end

  // Controller FSM with call latch, travel and door timers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      floor      <= '0;
      dir_up     <= 1'b1;
      moving     <= 1'b0;
      door_open  <= 1'b0;
      pending    <= '0;
      fire_mode  <= 1'b0;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      pending <= pending_merge;
      if (firealarm && !fire_mode) begin
        // Fire overrides everything, including a held door
        fire_mode  <= 1'b1;
        travel_cnt <= '0;
        door_cnt   <= '0;
        if (floor == FIRE_F) begin
          state     <= FIRE_PARKED;
          door_open <= 1'b1;
          moving    <= 1'b0;
        end else begin
          state     <= FIRE_RECALL;
          door_open <= 1'b0;
          moving    <= 1'b1;
          dir_up    <= (FIRE_F > floor);
        end
      end else begin
        case (state)
          IDLE: begin
            if (pending[floor]) begin
              state     <= DOOR_OPEN;
              door_open <= 1'b1;
              door_cnt  <= '0;
              pending   <= pending_merge & ~floor_bit(floor);
            end else if (|pending) begin
              state      <= MOVING;
              moving     <= 1'b1;
              travel_cnt <= '0;
              dir_up     <= any_above && (dir_up || !any_below);
            end
          end
          MOVING: begin
            if (travel_cnt == TRAVEL_LAST) begin
              travel_cnt <= '0;
              floor      <= arrive_floor;
              if (pending[arrive_floor]) begin
                state     <= DOOR_OPEN;
                moving    <= 1'b0;
                door_open <= 1'b1;
                door_cnt  <= '0;
                pending   <= pending_merge & ~floor_bit(arrive_floor);
              end else if (dir_up ? arr_above : arr_below) begin
                state <= MOVING;
              end else if (dir_up ? arr_below : arr_above) begin
                dir_up <= !dir_up;
              end else begin
                state  <= IDLE;
                moving <= 1'b0;
              end
            end else begin
              travel_cnt <= travel_cnt + TW'(1);
            end
          end
          DOOR_OPEN: begin
            pending <= pending_merge & ~floor_bit(floor);
            if (person_detected || overload || req[floor]) begin
              door_cnt <= '0;
            end else if (door_cnt == DOOR_LAST) begin
              state     <= IDLE;
              door_open <= 1'b0;
              door_cnt  <= '0;
            end else begin
              door_cnt <= door_cnt + DW'(1);
            end
          end
          FIRE_RECALL: begin
            if (travel_cnt == TRAVEL_LAST) begin
              travel_cnt <= '0;
              floor      <= arrive_floor;
              if (arrive_floor == FIRE_F) begin
                state     <= FIRE_PARKED;
                door_open <= 1'b1;
                moving    <= 1'b0;
              end
            end else begin
              travel_cnt <= travel_cnt + TW'(1);
            end
          end
          FIRE_PARKED: begin
            if (!firealarm) begin
              state     <= IDLE;
              door_open <= 1'b0;
              fire_mode <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign door_closed = ~door_open;
  assign bcd_floor   = 4'(floor);

`ifdef ELEV_SEG_EN
  logic [6:0] seg_comb;

  elevator_seg_dec u_seg_dec (
    .bcd (bcd_floor),
    .seg (seg_comb)
  );

  // Display image lags the floor by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg <= SEG_0;
    else     seg <= seg_comb;
  end
`else
  assign seg = 7'b0000000;
`endif

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed self-checking bench for elevator_scan_ctrl (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       overload = 1'b0;
  logic       firealarm = 1'b0;
  logic       person_detected = 1'b0;
  logic       door_open, door_closed, dir_up, moving, fire_mode;
  logic [2:0] floor;
  logic [3:0] bcd_floor;
  logic [7:0] pending;
  logic [6:0] seg;

  int total = 0;
  int bad = 0;

`ifdef ELEV_SEG_EN
  localparam logic [6:0] EXP_SEG_0 = 7'b1111110;
  localparam logic [6:0] EXP_SEG_2 = 7'b1101101;
  localparam logic [6:0] EXP_SEG_3 = 7'b1111001;
`else
  localparam logic [6:0] EXP_SEG_0 = 7'b0000000;
  localparam logic [6:0] EXP_SEG_2 = 7'b0000000;
  localparam logic [6:0] EXP_SEG_3 = 7'b0000000;
`endif

  elevator_scan_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .overload        (overload),
    .firealarm       (firealarm),
    .person_detected (person_detected),
    .door_open       (door_open),
    .door_closed     (door_closed),
    .floor           (floor),
    .bcd_floor       (bcd_floor),
    .dir_up          (dir_up),
    .moving          (moving),
    .pending         (pending),
    .fire_mode       (fire_mode),
    .seg             (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({door_open, door_closed, floor, dir_up, moving, pending, fire_mode, bcd_floor} !==
        {1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_outputs got door=%b closed=%b floor=%0d up=%b mov=%b pend=%h fire=%b bcd=%0d",
               door_open, door_closed, floor, dir_up, moving, pending, fire_mode, bcd_floor);
    end
    total++;
    if (seg !== EXP_SEG_0) begin
      bad++; $display("FAIL reset_seg got=%b want=%b", seg, EXP_SEG_0);
    end
    rst = 1'b0;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_single_call();
    int n;
    req = 8'h08;
    tick();
    req = 8'h00;
    total++;
    if (pending !== 8'h08 || moving !== 1'b0) begin
      bad++; $display("FAIL call_latch pend=%h mov=%b want pend=08 mov=0", pending, moving);
    end
    tick();
    total++;
    if (moving !== 1'b1 || dir_up !== 1'b1) begin
      bad++; $display("FAIL start_up mov=%b up=%b want 1 1", moving, dir_up);
    end
    n = 0;
    while (!door_open && n < 40) begin tick(); n++; end
    total++;
    if (n !== 12 || floor !== 3'd3 || pending !== 8'h00 || moving !== 1'b0) begin
      bad++; $display("FAIL arrive_3 cycles=%0d floor=%0d pend=%h mov=%b want 12 3 00 0", n, floor, pending, moving);
    end
    n = 0;
    while (door_open && n < 40) begin tick(); n++; end
    total++;
    if (n !== 6 || door_closed !== 1'b1) begin
      bad++; $display("FAIL door_time_3 open=%0d closed=%b want 6 1", n, door_closed);
    end
    $display("test_single_call: floor=%0d", floor);
  endtask

  task automatic test_scan_order();
    int n;
    req = 8'h22;
    tick();
    req = 8'h00;
    n = 0;
    while (!door_open && n < 40) begin tick(); n++; end
    total++;
    if (floor !== 3'd5 || pending !== 8'h02 || dir_up !== 1'b1) begin
      bad++; $display("FAIL scan_first floor=%0d pend=%h up=%b want 5 02 1", floor, pending, dir_up);
    end
    n = 0;
    while (door_open && n < 40) begin tick(); n++; end
    tick();
    total++;
    if (moving !== 1'b1 || dir_up !== 1'b0) begin
      bad++; $display("FAIL scan_reverse mov=%b up=%b want 1 0", moving, dir_up);
    end
    n = 0;
    while (!door_open && n < 40) begin tick(); n++; end
    total++;
    if (n !== 16 || floor !== 3'd1 || pending !== 8'h00) begin
      bad++; $display("FAIL scan_second cycles=%0d floor=%0d pend=%h want 16 1 00", n, floor, pending);
    end
    n = 0;
    while (door_open && n < 40) begin tick(); n++; end
    $display("test_scan_order: floor=%0d up=%b", floor, dir_up);
  endtask

  task automatic test_door_hold();
    int n;
    int lows;
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    total++;
    if (door_open !== 1'b1) begin
      bad++; $display("FAIL hold_open got=%b want 1", door_open);
    end
    n = 1;
    person_detected = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (door_open) n++; end
    person_detected = 1'b0;
    for (int i = 0; i < 40 && door_open; i++) begin tick(); if (door_open) n++; end
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL person_hold open=%0d want 16", n);
    end
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    overload = 1'b1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (!door_open) lows++; end
    total++;
    if (lows !== 0) begin
      bad++; $display("FAIL overload_hold closed_cycles=%0d want 0", lows);
    end
    overload = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && door_open; i++) begin tick(); if (door_open) n++; end
    total++;
    if (n !== 5 || door_closed !== 1'b1) begin
      bad++; $display("FAIL overload_release open=%0d closed=%b want 5 1", n, door_closed);
    end
    $display("test_door_hold: done");
  endtask

  task automatic test_fire_recall();
    int n;
    req = 8'h40;
    tick();
    req = 8'h00;
    n = 0;
    while (!(floor == 3'd4 && moving) && n < 40) begin tick(); n++; end
    firealarm = 1'b1;
    tick();
    total++;
    if (fire_mode !== 1'b1 || pending !== 8'h00 || door_open !== 1'b0 || dir_up !== 1'b0 || moving !== 1'b1) begin
      bad++; $display("FAIL fire_entry fire=%b pend=%h door=%b up=%b mov=%b want 1 00 0 0 1",
                      fire_mode, pending, door_open, dir_up, moving);
    end
    req = 8'hFF;
    n = 0;
    while (!door_open && n < 40) begin tick(); n++; end
    total++;
    if (n !== 16 || floor !== 3'd0 || pending !== 8'h00 || fire_mode !== 1'b1 || moving !== 1'b0) begin
      bad++; $display("FAIL fire_park cycles=%0d floor=%0d pend=%h fire=%b mov=%b want 16 0 00 1 0",
                      n, floor, pending, fire_mode, moving);
    end
    req = 8'h00;
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (door_open) n++; end
    total++;
    if (n !== 5) begin
      bad++; $display("FAIL fire_held open=%0d want 5", n);
    end
    firealarm = 1'b0;
    tick();
    total++;
    if (door_open !== 1'b0 || door_closed !== 1'b1 || fire_mode !== 1'b0 || moving !== 1'b0) begin
      bad++; $display("FAIL fire_release door=%b closed=%b fire=%b mov=%b want 0 1 0 0",
                      door_open, door_closed, fire_mode, moving);
    end
    $display("test_fire_recall: floor=%0d", floor);
  endtask

  task automatic test_fire_at_landing();
    req = 8'h01;
    firealarm = 1'b1;
    tick();
    req = 8'h00;
    total++;
    if (fire_mode !== 1'b1 || door_open !== 1'b1 || moving !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL fire_direct fire=%b door=%b mov=%b pend=%h want 1 1 0 00",
                      fire_mode, door_open, moving, pending);
    end
    firealarm = 1'b0;
    tick();
    tick();
    total++;
    if (door_open !== 1'b0 || fire_mode !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL fire_direct_exit door=%b fire=%b pend=%h want 0 0 00", door_open, fire_mode, pending);
    end
    $display("test_fire_at_landing: done");
  endtask

  task automatic test_async_reset();
    int n;
    req = 8'h20;
    tick();
    req = 8'h00;
    n = 0;
    while (!(floor == 3'd2 && moving) && n < 40) begin tick(); n++; end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({door_open, door_closed, floor, dir_up, moving, pending, fire_mode, bcd_floor} !==
        {1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL async_reset door=%b closed=%b floor=%0d up=%b mov=%b pend=%h fire=%b bcd=%0d",
               door_open, door_closed, floor, dir_up, moving, pending, fire_mode, bcd_floor);
    end
    total++;
    if (seg !== EXP_SEG_0) begin
      bad++; $display("FAIL async_reset_seg got=%b want=%b", seg, EXP_SEG_0);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("test_async_reset: done");
  endtask

  task automatic test_seg_and_reopen();
    int n;
    req = 8'h08;
    tick();
    req = 8'h00;
    n = 0;
    while (!door_open && n < 40) begin tick(); n++; end
    total++;
    if (floor !== 3'd3 || bcd_floor !== 4'd3 || seg !== EXP_SEG_2) begin
      bad++; $display("FAIL seg_lag floor=%0d bcd=%0d seg=%b want 3 3 %b", floor, bcd_floor, seg, EXP_SEG_2);
    end
    tick();
    total++;
    if (seg !== EXP_SEG_3) begin
      bad++; $display("FAIL seg_digit got=%b want=%b", seg, EXP_SEG_3);
    end
    tick(); tick();
    req = 8'h08;
    tick();
    req = 8'h00;
    total++;
    if (pending !== 8'h00 || door_open !== 1'b1) begin
      bad++; $display("FAIL reopen_clear pend=%h door=%b want 00 1", pending, door_open);
    end
    n = 0;
    while (door_open && n < 40) begin tick(); n++; end
    total++;
    if (n !== 6) begin
      bad++; $display("FAIL reopen_timer open=%0d want 6", n);
    end
    $display("test_seg_and_reopen: done");
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_order();
    test_door_hold();
    test_fire_recall();
    test_fire_at_landing();
    test_async_reset();
    test_seg_and_reopen();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
